alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  Operand-fetch/write-back sequencer directly upstream of the 16-bit ALU (op 00 add, 01 sub, 10 and, 11 or).
//  Holds an 8x16 register file, accepts one command {op,rd,rs1,rs2} via valid/ready and drives the ALU.
//  Captures the ALU result and carry out, then writes the result back to rd.
//  Multi-cycle, one command in flight; 4-cycle command period.
// PARAMETERS
//  WIDTH  16  datapath width; fixed at 16 to match the ALU
//  AW     3   register address width; NREGS = 2**AW = 8
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      asynchronous, active-low reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      stage can accept a command this cycle
//  cmd_op     in   2      ALU op for the command
//  cmd_rd     in   AW     destination register
//  cmd_rs1    in   AW     source for ALU i0
//  cmd_rs2    in   AW     source for ALU i1
//  ld_en      in   1      host register load strobe
//  ld_addr    in   AW     host load address
//  ld_data    in   WIDTH  host load data
//  dbg_addr   in   AW     debug read address
//  dbg_data   out  WIDTH  combinational read of regfile[dbg_addr]
//  alu_op     out  2      to ALU op
//  alu_a      out  WIDTH  to ALU i0
//  alu_b      out  WIDTH  to ALU i1
//  alu_o      in   WIDTH  from ALU o
//  alu_cout   in   1      from ALU cout
//  done       out  1      one-cycle pulse: result/carry valid, write-back this edge
//  result     out  WIDTH  last ALU result, held until next done
//  carry      out  1      carry flag
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, all regs and operand latches = 0.
//   alu_op=00, alu_a=alu_b=0, result=0, carry=0, done=0; cmd_ready=1 once reset releases.
//  FSM: IDLE -> FETCH -> EXEC -> WB -> IDLE.
//   IDLE:  cmd_ready = ~ld_en. Accept on cmd_valid & cmd_ready; latch op/rd/rs1/rs2 -> FETCH.
//   FETCH: opA <= reg[rs1], opB <= reg[rs2], alu_op <= op -> EXEC.
//   EXEC:  alu_a/alu_b/alu_op driven from latches, stable; result <= alu_o, cout latched -> WB.
//   WB:    done=1; reg[rd] <= result at the closing edge; carry <= cout only if op[1]==0; -> IDLE.
//  cmd_ready=0 in FETCH/EXEC/WB. Accept edge E0 -> done high in cycle after E2.
//  Back-to-back commands: period 4 cycles.
//  rd==rs1/rs2: operands are latched in FETCH, so the old value is used.
//   The next command reads the written value (no bypass needed).
//  ld_en honoured only in IDLE: reg[ld_addr] <= ld_data; ignored in other states.
//   ld_en has priority over cmd_valid in the same IDLE cycle (cmd_ready=0).
//  alu_a/alu_b hold their last values in IDLE (no toggling); result/carry hold between commands.
//  All AW-bit addresses are valid; no out-of-range case.
//  Arithmetic is entirely in the ALU; no width extension.
//   sub carry=1 means no borrow (i0 >= i1 unsigned).
//  Reset mid-command: abort immediately, no write-back, no done.
// CONFIGURATION
//  REGFILE_R0_ZERO_EN defined:
//   reg[0] always reads 0 (operand fetch and dbg_data).
//   Writes to reg[0] (ld or WB) are discarded; done still pulses with the computed result.
//  REGFILE_R0_ZERO_EN undefined: reg[0] is an ordinary register.
// TESTING
//  1 ld r1=0x0005, r2=0x0003; cmd op=00 rd=3 rs1=1 rs2=2 -> done 3 edges after accept,
//    result=0x0008, carry=0, dbg r3=0x0008.
//  2 sub r1=0x0005, r2=0x0003 -> 0x0002, carry=1;
//    sub r1=0x0003, r2=0x0005 -> 0xFFFE, carry=0.
//  3 add 0xFFFF+0x0001 -> result 0x0000, carry=1;
//    then and 0xF0F0 & 0x0FF0 -> 0x00F0 with carry still 1; or -> 0xFFF0.
//  4 r1=1, cmd_valid held for two cmds r1=r1+r1 -> cmd_ready low 3 cycles between accepts,
//    r1=0x0002 then 0x0004.
//  5 ld_en and cmd_valid together in IDLE -> ld written, cmd accepted next cycle using the new value;
//    reset pulled low in EXEC -> no done, all regs 0, cmd_ready=1 after release.
//  6 With REGFILE_R0_ZERO_EN: ld r0=0x1234 then add rd=0 -> dbg r0=0x0000;
//    add rs1=0 rs2=2 (r2=3) -> result 0x0003.

Source files
------------

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - 8x16 register file with fetch/exec/write-back sequencing around an external 16-bit ALU
// Optional build macro: REGFILE_R0_ZERO_EN (r0 hard-wired to zero).
module alu_operand_stage #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_cout,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int NREGS = 2 ** AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] regs [NREGS];
    logic [1:0]       op_q;
    logic [AW-1:0]    rd_q, rs1_q, rs2_q;
    logic [WIDTH-1:0] op_a, op_b;
    logic [1:0]       alu_op_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             carry_q;
    logic             accept;

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    function automatic logic [WIDTH-1:0] rf_read(input logic [AW-1:0] a);
`ifdef REGFILE_R0_ZERO_EN
        rf_read = (a == '0) ? '0 : regs[a];
`else
        rf_read = regs[a];
`endif
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FETCH;
            FETCH:   state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A host load in the same IDLE cycle wins over a pending command.
    always_comb begin
        cmd_ready = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    cmd_ready = ~ld_en;
            WB:      done      = 1'b1;
            default: ;
        endcase
    end

    assign accept = cmd_valid & cmd_ready;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ld_addr;
        wr_data = ld_data;
        if (state == IDLE && ld_en) begin
            wr_en = 1'b1;
        end else if (state == WB) begin
            wr_en   = 1'b1;
            wr_addr = rd_q;
            wr_data = result_q;
        end
`ifdef REGFILE_R0_ZERO_EN
        if (wr_addr == '0) wr_en = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs <= '{default: '0};
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        rs1_q <= cmd_rs1;
                        rs2_q <= cmd_rs2;
                    end
                end
                // Operands are captured here, so rd==rs uses the pre-write value.
                FETCH: begin
                    op_a     <= rf_read(rs1_q);
                    op_b     <= rf_read(rs2_q);
                    alu_op_q <= op_q;
                end
                EXEC: begin
                    result_q <= alu_o;
                    cout_q   <= alu_cout;
                end
                WB: begin
                    if (!op_q[1]) carry_q <= cout_q;
                end
                default: ;
            endcase
        end
    end

    assign alu_op   = alu_op_q;
    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign result   = result_q;
    assign carry    = carry_q;
    assign dbg_data = rf_read(dbg_addr);

endmodule
